// File: rtl/nexys_starship_game_ctrl.sv
// Nexys Starship top-level game controller: IDLE/PLAY/OVER sequencing, game tick
// generation, survival score and per-lane random spawn pulses for the four lane FSMs.
module nexys_starship_game_ctrl #(
   parameter int          TICK_DIV  = 100_000_000,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       start_btn,
   input  logic [3:0] lane_gameover,
   output logic       play_flag,
   output logic       gameover_ctrl,
   output logic       timer_clk,
   output logic [3:0] lane_random,
   output logic [7:0] score,
   output logic       q_Idle,
   output logic       q_Play,
   output logic       q_Over
);

   localparam int             CntW   = $clog2(TICK_DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      Idle = 3'b001,
      Play = 3'b010,
      Over = 3'b100
   } state_t;

   state_t            state_q, state_d;
   logic [CntW-1:0]   tickCnt_q, tickCnt_d;
   logic [7:0]        score_q, score_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic              timerClk_q, timerClk_d;
   logic [3:0]        laneRandom_q, laneRandom_d;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= Idle;
         tickCnt_q    <= '0;
         score_q      <= 8'd0;
         lfsr_q       <= LFSR_SEED;
         timerClk_q   <= 1'b0;
         laneRandom_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         tickCnt_q    <= tickCnt_d;
         score_q      <= score_d;
         lfsr_q       <= lfsr_d;
         timerClk_q   <= timerClk_d;
         laneRandom_q <= laneRandom_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      tickCnt_d    = '0;
      score_d      = score_q;
      timerClk_d   = 1'b0;
      lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      laneRandom_d = 4'd0;

      // Spawn decisions use the LFSR value before this edge's shift.
      for (int i = 0; i < 4; i++) begin
         laneRandom_d[i] = (state_q == Play) && (lfsr_q[4*i +: 4] == 4'hF);
      end

      case (state_q)
         Idle: begin
            if (start_btn) begin
               state_d = Play;
               score_d = 8'd0;
            end
         end
         Play: begin
            // A lane loss beats a coincident tick: no pulse, no score.
            if (|lane_gameover) begin
               state_d = Over;
            end else if (tickCnt_q == CntMax) begin
               timerClk_d = 1'b1;
               if (score_q != 8'hFF) begin
                  score_d = score_q + 8'd1;
               end
            end else begin
               tickCnt_d = tickCnt_q + CntW'(1);
            end
         end
         Over: begin
            if (start_btn) begin
               state_d = Idle;
            end
         end
         default: begin
            state_d = Idle;
         end
      endcase
   end

   assign play_flag     = (state_q == Play);
   assign gameover_ctrl = (state_q == Over);
   assign q_Idle        = (state_q == Idle);
   assign q_Play        = (state_q == Play);
   assign q_Over        = (state_q == Over);
   assign timer_clk     = timerClk_q;
   assign lane_random   = laneRandom_q;
   assign score         = score_q;

endmodule

// File: doc/nexys_starship_game_ctrl.md
# nexys_starship_game_ctrl

Top-level game controller for Nexys Starship, directly upstream of the four lane monster FSMs (left/up/right/down). It runs the IDLE/PLAY/OVER game state machine and drives each lane's `play_flag`, `gameover_ctrl`, `timer_clk` and per-lane random spawn pulses. It also collects the lane game-over flags and keeps a survival score for the display.

## Interface

**Parameters**
- `TICK_DIV`, default 100_000_000: Clk cycles per game tick (1 s at 100 MHz); minimum 2.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

**Ports**
- `Clk`  in  1  system clock; all logic on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `start_btn`  in  1  debounced single-cycle start/acknowledge pulse.
- `lane_gameover`  in  4  {down, right, up, left} lane game-over flags.
- `play_flag`  out  1  high only in PLAY.
- `gameover_ctrl`  out  1  high only in OVER.
- `timer_clk`  out  1  one-Clk-cycle tick pulse, PLAY only.
- `lane_random`  out  4  per-lane spawn pulses, same bit order as `lane_gameover`.
- `score`  out  8  ticks survived in the current or last game.
- `q_Idle`, `q_Play`, `q_Over`  out  1 each  one-hot state decode.

## Operation

**Reset and output timing**
- Reset low forces, immediately: state IDLE, tick counter 0, `score` 0, LFSR = `LFSR_SEED`, all outputs 0 except `q_Idle`=1.
- Every output is a register or a decode of registered state. No combinational path runs from inputs to outputs.

**State machine** (one-hot {OVER, PLAY, IDLE} = 3'b100, 3'b010, 3'b001)
- IDLE: on `start_btn` go to PLAY and clear `score` to 0. `lane_gameover` is ignored.
- PLAY: if any `lane_gameover` bit is set, go to OVER. `start_btn` is ignored.
- OVER: on `start_btn` go to IDLE. `score` is frozen. `lane_gameover` is ignored.
- Any illegal encoding returns to IDLE on the next edge.

**Tick counter**
- Width is `$clog2(TICK_DIV)`. It is held at 0 outside PLAY.
- In PLAY it counts 0..TICK_DIV-1 and wraps to 0.
- On the wrap edge: `timer_clk` is 1 for the following cycle, and `score` increments, saturating at 255.
- If `lane_gameover` is seen on the wrap edge, game-over wins: no `timer_clk` pulse and no `score` increment.

**LFSR**
- 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
- Shifts every Clk in all states (free-running).
- Next value: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.

**Spawn pulses**
- Registered: lane_random[i] <= (state==PLAY) && (lfsr[4i+3:4i]==4'hF), using the pre-shift LFSR value.
- Forced to 0 outside PLAY.

## Timing

- `start_btn` sampled high in IDLE at edge N: `q_Play`=1 and `play_flag`=1 from edge N, i.e. visible in cycle N+1.
- First `timer_clk` pulse is high during the cycle starting at edge N+TICK_DIV. It then repeats every TICK_DIV cycles.
- `score` updates on the same edge that raises `timer_clk`.
- `lane_gameover` seen in PLAY at edge M: from edge M, `gameover_ctrl`=1, `play_flag`=0 and the counter is 0. `timer_clk` and `lane_random` are 0 from edge M+1 at the latest.
- `gameover_ctrl` stays high until `start_btn`, with no minimum hold. Lanes sample it with a one-cycle register, so it is held at least 1 cycle because `start_btn` is a user event.
- Reset asserted mid-game takes effect asynchronously. Release is synchronous to the next Clk edge.
- `timer_clk` is used as a clock by the lanes, so it must come straight from a flop, never from a combinational decode.

## Test plan

All scenarios use TICK_DIV=4 unless stated.

1. **Reset:** drive Reset=0 in PLAY with score=3 → same cycle `q_Idle`=1, `play_flag`=0, `score`=0, `timer_clk`=0. After release, the first shifts match an LFSR model seeded 16'hACE1.
2. **Start and ticks:** `start_btn` pulse at edge 0 → `play_flag`=1 from edge 0; `timer_clk` high in cycles starting at edges 4, 8, 12; `score` = 1, 2, 3 at those edges.
3. **Game over and restart:** `lane_gameover`=4'b0100 at edge 10 → `gameover_ctrl`=1, `play_flag`=0, `score` held at 2. `start_btn` → IDLE with `gameover_ctrl`=0. A second `start_btn` → PLAY with `score`=0.
4. **Saturation:** TICK_DIV=2, 600 cycles in PLAY → `score` reaches 255 and stays 255.
5. **Spawn gating:** 1000 cycles in IDLE and in OVER → `lane_random`=0 throughout. In PLAY, each bit matches the LFSR model cycle-for-cycle and pulses at least once in 1000 cycles.
6. **Simultaneous events:** `lane_gameover` on the wrap edge → no `timer_clk` pulse and `score` unchanged. `start_btn` together with `lane_gameover` in PLAY → OVER.
